// File: rtl/change_payout_ctrl_pkg.sv
// Shared definitions for the change payout controller: coin values,
// FSM state type, coin selector type and the debug snapshot struct.
package vend_pkg;

  localparam int AMT_W_DEF = 8;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_25 = 25;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_FINISH   = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_Q    = 2'd1,   // 25c
    COIN_D    = 2'd2,   // 10c
    COIN_N    = 2'd3    // 5c
  } coin_t;

  // Debug snapshot: FSM state, coin in flight and tube full/empty flags
  // ordered {25, 10, 5}.
  typedef struct packed {
    state_t     state;
    coin_t      coin;
    logic [2:0] tube_full;
    logic [2:0] tube_empty;
  } dbg_t;

  function automatic int coin_value(coin_t c);
    case (c)
      COIN_Q:  return COIN_25;
      COIN_D:  return COIN_10;
      COIN_N:  return COIN_5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/change_payout_ctrl_if.sv
// Request/result channel between the vend FSM (master) and the payout
// controller (slave).
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_amount must be stable while req_valid is
// high. req_valid seen while req_ready is low is ignored, not queued.
// done is a one-cycle pulse; paid_out/shortfall are valid with it and held.
interface change_payout_ctrl_if #(
  parameter int AMT_W = 8
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             done;
  logic [AMT_W-1:0] paid_out;
  logic [AMT_W-1:0] shortfall;

  modport master (
    output req_valid, req_amount,
    input  req_ready, done, paid_out, shortfall
  );

  modport slave (
    input  req_valid, req_amount,
    output req_ready, done, paid_out, shortfall
  );
endinterface

// File: rtl/change_payout_ctrl_tube.sv
// Saturating coin tube inventory counter. inc and dec together leave the
// count unchanged (a coin in and a coin out of the same tube).
module coin_tube_counter #(
  parameter int CNT_W = 5,
  parameter int MAX   = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  assign full  = (count == CNT_W'(MAX));
  assign empty = (count == '0);

  // Count register: saturate at MAX on refill, never go below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout controller: accepts a change amount, ejects coins greedily
// (25c, 10c, 5c) one at a time waiting for the hopper drop sensor, tracks
// tube inventory and latches a sticky fault when the hopper stalls.
// Optional feature macro: EXACT_CHANGE_LAMP_EN adds the exact_only output.
module change_payout_ctrl
  import vend_pkg::*;
#(
  parameter int AMT_W       = AMT_W_DEF,
  parameter int CNT_W       = 5,
  parameter int TUBE_MAX    = 31,
  parameter int ACK_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  change_payout_ctrl_if.slave req,
  output logic               eject_25,
  output logic               eject_10,
  output logic               eject_5,
  input  logic               hopper_ack,
  input  logic               refill_25,
  input  logic               refill_10,
  input  logic               refill_5,
  output logic [CNT_W-1:0]   cnt_25,
  output logic [CNT_W-1:0]   cnt_10,
  output logic [CNT_W-1:0]   cnt_5,
  output logic               busy,
  output logic               fault,
  input  logic               fault_clr,
`ifdef EXACT_CHANGE_LAMP_EN
  output logic               exact_only,
`endif
  output dbg_t               dbg
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_t           state, state_next;
  coin_t            coin_sel, sel_next;
  logic [AMT_W-1:0] remaining, paid, paid_out_q, shortfall_q, coin_amt;
  logic [TMR_W-1:0] timer;
  logic             done_q;

  logic accept, load_sel, ack_take, to_fault, to_finish;
  logic full_25, full_10, full_5, empty_25, empty_10, empty_5;
  logic avail_25, avail_10, avail_5;

  assign coin_amt = AMT_W'(coin_value(coin_sel));

  // A coin is usable only if it fits in what is left and the tube has stock,
  // so remaining can never underflow.
  assign avail_25 = (remaining >= AMT_W'(COIN_25)) && !empty_25;
  assign avail_10 = (remaining >= AMT_W'(COIN_10)) && !empty_10;
  assign avail_5  = (remaining >= AMT_W'(COIN_5))  && !empty_5;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode, eject strobes and datapath control pulses.
  always_comb begin
    state_next = state;
    sel_next   = COIN_NONE;
    accept     = 1'b0;
    load_sel   = 1'b0;
    ack_take   = 1'b0;
    to_fault   = 1'b0;
    to_finish  = 1'b0;
    eject_25   = 1'b0;
    eject_10   = 1'b0;
    eject_5    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req.req_valid && !fault) begin
          accept     = 1'b1;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        load_sel = 1'b1;
        if (avail_25)      sel_next = COIN_Q;
        else if (avail_10) sel_next = COIN_D;
        else if (avail_5)  sel_next = COIN_N;
        if (sel_next != COIN_NONE) begin
          state_next = ST_EJECT;
        end else begin
          to_finish  = 1'b1;
          state_next = ST_FINISH;
        end
      end
      ST_EJECT: begin
        eject_25   = (coin_sel == COIN_Q);
        eject_10   = (coin_sel == COIN_D);
        eject_5    = (coin_sel == COIN_N);
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (hopper_ack) begin
          ack_take   = 1'b1;
          state_next = ST_SELECT;
        end else if (timer >= TMR_LAST) begin
          to_fault   = 1'b1;
          state_next = ST_FAULT;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Payout datapath: remaining/paid accumulation, ack timer, result latch,
  // done pulse and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining   <= '0;
      paid        <= '0;
      coin_sel    <= COIN_NONE;
      timer       <= '0;
      paid_out_q  <= '0;
      shortfall_q <= '0;
      done_q      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      done_q <= to_finish || to_fault;
      if (accept) begin
        remaining <= req.req_amount;
        paid      <= '0;
      end
      if (load_sel) coin_sel <= sel_next;
      if (state == ST_EJECT)         timer <= '0;
      else if (state == ST_WAIT_ACK) timer <= timer + TMR_W'(1);
      if (ack_take) begin
        remaining <= remaining - coin_amt;
        paid      <= paid + coin_amt;
      end
      if (to_finish || to_fault) begin
        paid_out_q  <= paid;
        shortfall_q <= remaining;
      end
      if (to_fault)                             fault <= 1'b1;
      else if (state == ST_FAULT && fault_clr)  fault <= 1'b0;
    end
  end

  coin_tube_counter #(.CNT_W(CNT_W), .MAX(TUBE_MAX)) u_tube_25 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_25),
    .dec   (ack_take && (coin_sel == COIN_Q)),
    .count (cnt_25),
    .full  (full_25),
    .empty (empty_25)
  );

  coin_tube_counter #(.CNT_W(CNT_W), .MAX(TUBE_MAX)) u_tube_10 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_10),
    .dec   (ack_take && (coin_sel == COIN_D)),
    .count (cnt_10),
    .full  (full_10),
    .empty (empty_10)
  );

  coin_tube_counter #(.CNT_W(CNT_W), .MAX(TUBE_MAX)) u_tube_5 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_5),
    .dec   (ack_take && (coin_sel == COIN_N)),
    .count (cnt_5),
    .full  (full_5),
    .empty (empty_5)
  );

`ifdef EXACT_CHANGE_LAMP_EN
  // Lamp is lit when small change cannot be made: no nickels, or no dimes
  // and fewer than four nickels. Lit out of reset since all tubes are empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exact_only <= 1'b1;
    else     exact_only <= (cnt_5 == '0) || ((cnt_10 == '0) && (cnt_5 < CNT_W'(4)));
  end
`endif

  assign busy          = (state != ST_IDLE);
  assign req.req_ready = (state == ST_IDLE) && !fault;
  assign req.done      = done_q;
  assign req.paid_out  = paid_out_q;
  assign req.shortfall = shortfall_q;

  assign dbg.state      = state;
  assign dbg.coin       = coin_sel;
  assign dbg.tube_full  = {full_25, full_10, full_5};
  assign dbg.tube_empty = {empty_25, empty_10, empty_5};

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Directed testbench for change_payout_ctrl with an expected-result queue
// checked by a monitor that runs alongside the stimulus.
module tb_change_payout_ctrl;
  import vend_pkg::*;

  localparam int AMT_W = 8;
  localparam int CNT_W = 5;
  localparam int TUBE_MAX = 31;
  localparam int ACK_TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  change_payout_ctrl_if #(.AMT_W(AMT_W)) bus ();

  logic eject_25, eject_10, eject_5;
  logic hopper_ack = 1'b0;
  logic refill_25 = 1'b0, refill_10 = 1'b0, refill_5 = 1'b0;
  logic [CNT_W-1:0] cnt_25, cnt_10, cnt_5;
  logic busy, fault;
  logic fault_clr = 1'b0;
  dbg_t dbg;
`ifdef EXACT_CHANGE_LAMP_EN
  logic exact_only;
`endif

  change_payout_ctrl #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .TUBE_MAX(TUBE_MAX), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .eject_25   (eject_25),
    .eject_10   (eject_10),
    .eject_5    (eject_5),
    .hopper_ack (hopper_ack),
    .refill_25  (refill_25),
    .refill_10  (refill_10),
    .refill_5   (refill_5),
    .cnt_25     (cnt_25),
    .cnt_10     (cnt_10),
    .cnt_5      (cnt_5),
    .busy       (busy),
    .fault      (fault),
    .fault_clr  (fault_clr),
`ifdef EXACT_CHANGE_LAMP_EN
    .exact_only (exact_only),
`endif
    .dbg        (dbg)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];     // {paid_out, shortfall} per expected done
  logic [7:0]  exp_ej_q[$];  // coin value per expected eject strobe
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    logic [15:0] e;
    logic [7:0]  v;
    forever begin
      @(negedge clk);
      if (eject_25 || eject_10 || eject_5) begin
        chk("eject_onehot", 32'(eject_25) + 32'(eject_10) + 32'(eject_5), 32'd1);
        v = eject_25 ? 8'd25 : (eject_10 ? 8'd10 : 8'd5);
        if (exp_ej_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_eject: got coin %0d expected none (t=%0t)", v, $time);
        end else begin
          chk("eject_coin", 32'(v), 32'(exp_ej_q.pop_front()));
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("paid_out", 32'(bus.paid_out), 32'(e[15:8]));
          chk("shortfall", 32'(bus.shortfall), 32'(e[7:0]));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_amount = '0;
    hopper_ack = 1'b0;
    refill_25 = 1'b0; refill_10 = 1'b0; refill_5 = 1'b0;
    fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic refill(input int n25, input int n10, input int n5);
    int m;
    m = (n25 > n10) ? n25 : n10;
    m = (m > n5) ? m : n5;
    for (int i = 0; i < m; i++) begin
      @(posedge clk);
      #1;
      refill_25 = (i < n25);
      refill_10 = (i < n10);
      refill_5  = (i < n5);
    end
    @(posedge clk);
    #1;
    refill_25 = 1'b0; refill_10 = 1'b0; refill_5 = 1'b0;
  endtask

  task automatic issue_req(input logic [7:0] amt);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_amount = amt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts negedges until an eject strobe, bounded.
  task automatic wait_eject(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (eject_25 || eject_10 || eject_5) return;
    end
    checks++;
    failures++;
    $display("FAIL eject_timeout: got no eject expected one within 100 cycles");
  endtask

  // Counts negedges until done, bounded.
  task automatic wait_done(input int bound, output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      n++;
      if (bus.done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: got no done expected one within %0d cycles", bound);
  endtask

  // Answers n ejects with hopper_ack d cycles after each strobe.
  task automatic pay_coins(input int n, input int d, input bit refill10_on_ack);
    int w;
    for (int i = 0; i < n; i++) begin
      wait_eject(w);
      repeat (d) @(posedge clk);
      #1;
      hopper_ack = 1'b1;
      refill_10 = refill10_on_ack;
      @(posedge clk);
      #1;
      hopper_ack = 1'b0;
      refill_10 = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_amount = '0;
    fork
      monitor_loop();
    join_none
    do_reset();
    @(negedge clk);
    chk("rst_cnt_25", 32'(cnt_25), 0);
    chk("rst_cnt_10", 32'(cnt_10), 0);
    chk("rst_cnt_5", 32'(cnt_5), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_paid_out", 32'(bus.paid_out), 0);
    chk("rst_shortfall", 32'(bus.shortfall), 0);
`ifdef EXACT_CHANGE_LAMP_EN
    chk("rst_exact_only", 32'(exact_only), 1);
`endif

    // Greedy 40c: 25, 10, 5
    refill(3, 2, 4);
    @(negedge clk);
    chk("stock_cnt_25", 32'(cnt_25), 3);
    chk("stock_cnt_10", 32'(cnt_10), 2);
    chk("stock_cnt_5", 32'(cnt_5), 4);
    exp_ej_q.push_back(8'd25); exp_ej_q.push_back(8'd10); exp_ej_q.push_back(8'd5);
    exp_q.push_back({8'd40, 8'd0});
    issue_req(8'd40);
    chk("busy_after_accept", 32'(busy), 1);
    wait_eject(n);
    chk("eject_latency", 32'(n), 2);
    // First strobe already seen; answer it then the remaining two.
    repeat (3) @(posedge clk);
    #1 hopper_ack = 1'b1;
    @(posedge clk);
    #1 hopper_ack = 1'b0;
    pay_coins(2, 3, 1'b0);
    wait_done(50, n);
    chk("done_latency", 32'(n), 2);
    @(negedge clk);
    chk("t1_cnt_25", 32'(cnt_25), 2);
    chk("t1_cnt_10", 32'(cnt_10), 1);
    chk("t1_cnt_5", 32'(cnt_5), 3);
    chk("t1_idle", 32'(busy), 0);

    // Short stock: 35c with 25x1, 5x1 pays 30, short 5
    do_reset();
    refill(1, 0, 1);
    exp_ej_q.push_back(8'd25); exp_ej_q.push_back(8'd5);
    exp_q.push_back({8'd30, 8'd5});
    issue_req(8'd35);
    pay_coins(2, 2, 1'b0);
    wait_done(50, n);
    @(negedge clk);
    chk("t2_cnt_25", 32'(cnt_25), 0);
    chk("t2_cnt_5", 32'(cnt_5), 0);

    // Zero and sub-nickel requests
    do_reset();
    refill(2, 2, 2);
    @(posedge clk);
    @(negedge clk);
`ifdef EXACT_CHANGE_LAMP_EN
    chk("exact_only_stocked", 32'(exact_only), 0);
`endif
    exp_q.push_back({8'd0, 8'd0});
    issue_req(8'd0);
    wait_done(50, n);
    chk("zero_done_latency", 32'(n), 2);
    exp_q.push_back({8'd0, 8'd3});
    issue_req(8'd3);
    wait_done(50, n);
    chk("three_done_latency", 32'(n), 2);

    // Hopper stall: no ack -> fault
    exp_ej_q.push_back(8'd25);
    exp_q.push_back({8'd0, 8'd25});
    issue_req(8'd25);
    wait_eject(n);
    wait_done(400, n);
    chk("fault_latency", 32'(n), ACK_TIMEOUT + 1);
    chk("fault_set", 32'(fault), 1);
    chk("fault_ready", 32'(bus.req_ready), 0);
    repeat (5) @(negedge clk);
    chk("fault_sticky", 32'(fault), 1);
    @(posedge clk);
    #1 fault_clr = 1'b1;
    @(posedge clk);
    #1 fault_clr = 1'b0;
    @(negedge clk);
    chk("fault_cleared", 32'(fault), 0);
    chk("fault_clr_ready", 32'(bus.req_ready), 1);
    chk("fault_cnt_25", 32'(cnt_25), 2);

    // Refill and debit on the same tube in the same cycle
    do_reset();
    refill(0, 1, 0);
    exp_ej_q.push_back(8'd10);
    exp_q.push_back({8'd10, 8'd0});
    issue_req(8'd10);
    pay_coins(1, 1, 1'b1);
    wait_done(50, n);
    @(negedge clk);
    chk("same_cycle_cnt_10", 32'(cnt_10), 1);
    refill(TUBE_MAX + 2, 0, 0);
    @(negedge clk);
    chk("sat_cnt_25", 32'(cnt_25), TUBE_MAX);

    // Reset during WAIT_ACK of a 3-coin payout
    do_reset();
    refill(3, 0, 0);
    exp_ej_q.push_back(8'd25);
    issue_req(8'd75);
    wait_eject(n);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_cnt_25", 32'(cnt_25), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ej", 32'({eject_25, eject_10, eject_5}), 0);
    chk("midrst_fault", 32'(fault), 0);
    chk("midrst_paid_out", 32'(bus.paid_out), 0);
    chk("midrst_shortfall", 32'(bus.shortfall), 0);
`ifdef EXACT_CHANGE_LAMP_EN
    chk("midrst_exact_only", 32'(exact_only), 1);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);

    // ---------------- final report ----------------
    chk("exp_done_drained", 32'(exp_q.size()), 0);
    chk("exp_eject_drained", 32'(exp_ej_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/change_payout_ctrl.md
Name: change_payout_ctrl

Overview:
Sequences coin-hopper ejection to pay out change after a vend. Accepts a change amount over a valid/ready handshake and pays it greedily from three coin tubes (25c, 10c, 5c), one coin at a time, waiting for the hopper's drop sensor between coins. Tracks tube inventory, reports amount paid and shortfall, and latches a fault if the hopper stalls. Sits between the vend FSM (change source) and the hopper drive/sensor interface.

Parameters:
AMT_W, 8, width of amount/paid/shortfall buses (cents)
CNT_W, 5, width of each tube counter
TUBE_MAX, 31, tube capacity in coins; counters saturate here, must be <= 2**CNT_W-1
ACK_TIMEOUT, 200, cycles to wait in WAIT_ACK for hopper_ack before faulting

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  change request present
req_amount  in  AMT_W  change to pay, cents
req_ready  out  1  high only in IDLE with fault=0
eject_25 / eject_10 / eject_5  out  1 each  one-cycle eject strobe; at most one high per cycle
hopper_ack  in  1  coin-drop sensor pulse; valid only in WAIT_ACK
refill_25 / refill_10 / refill_5  in  1 each  customer coin routed into tube; increment count
cnt_25 / cnt_10 / cnt_5  out  CNT_W each  current tube inventory
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of every accepted request
paid_out  out  AMT_W  total ejected for last request; valid with done, held until next accept
shortfall  out  AMT_W  unpaid remainder for last request; valid with done, held
fault  out  1  sticky hopper-timeout flag
fault_clr  in  1  clears fault, returns FAULT -> IDLE

Behaviour:
- Reset: state IDLE; all counts 0; eject_*, done, busy, fault 0; paid_out, shortfall 0; remaining, timer 0.
- States: IDLE, SELECT, EJECT, WAIT_ACK, FINISH, FAULT.
- IDLE: req_valid & req_ready -> latch remaining=req_amount, paid=0; go SELECT.
- SELECT: pick largest coin c in {25,10,5} with c <= remaining and cnt_c > 0. Found -> EJECT. None (includes remaining=0, remaining<5, or empty tubes) -> FINISH.
- EJECT: assert eject_c for exactly one cycle, clear timer -> WAIT_ACK.
- WAIT_ACK: hopper_ack -> cnt_c -= 1, remaining -= c, paid += c; go SELECT. timer reaches ACK_TIMEOUT with no ack -> fault=1, enter FAULT. Coin not debited.
- FINISH: done=1 for one cycle; paid_out=paid; shortfall=remaining; go IDLE.
- FAULT: done pulses on the entry cycle with paid_out/shortfall as accumulated. Remain until fault_clr, then IDLE with fault=0. req_ready=0 throughout.
- Latency: exact 25c request with stock: accept at T, eject_25 at T+2, ack at T+k, done at T+k+2.
- Inventory: refill_x increments cnt_x and saturates at TUBE_MAX (excess coin goes to the cashbox externally). If a refill and an ack debit hit the same tube in the same cycle, the count is unchanged. Multiple refill_* may be high together.
- hopper_ack outside WAIT_ACK is ignored. req_valid while busy is ignored (not queued).
- Arithmetic: remaining never underflows, because the coin is chosen only if c <= remaining. Amounts that are not a multiple of 5 leave the residue in shortfall.
- Reset mid-payout: everything returns to reset values, inventory included; no eject strobe after reset asserts.

Optional Feature:
EXACT_CHANGE_LAMP_EN: when defined, adds output exact_only (1 bit), registered from counts. It is 1 when cnt_5==0, or when cnt_10==0 and cnt_5<4, and is 1 out of reset. When undefined, the port and logic are absent.

Decomposition:
- Package vend_pkg: coin value constants COIN_5/10/25, state enum type, default AMT_W.
- Sub-module coin_tube_counter: saturating inc/dec counter with inc, dec, count, full, empty. Instantiate three times.

Test Plan:
- Refill 25x3, 10x2, 5x4; request 40; ack each coin after 3 cycles -> strobes 25,10,5 in that order; done with paid_out=40, shortfall=0; counts 2/1/3.
- Stock 25x1, 10x0, 5x1; request 35 -> ejects 25 then 5; paid_out=30, shortfall=5.
- Request 0, and separately request 3 with full stock -> no eject; done 2 cycles after accept; paid_out=0, shortfall=0 / 3.
- Request 25; never ack -> fault=1 after ACK_TIMEOUT cycles; done pulses with paid_out=0, shortfall=25; req_ready=0; fault_clr -> IDLE, req_ready=1, cnt_25 unchanged.
- cnt_10=1; refill_10 on the same cycle as the ack for a 10c eject -> cnt_10 stays 1. Refill a full tube -> count stays TUBE_MAX.
- Assert rst during WAIT_ACK of a 3-coin payout -> all outputs and counts 0 immediately; no further eject_*; with the macro defined, exact_only=1.
